// File: rtl/intersection_phase_scheduler.sv
// Actuated NS/EW intersection scheduler with a pedestrian walk phase; lights are a Moore decode of the state register.
// Time advances only on tick strobes; outputs change on the same edge that commits a transition.
module intersection_phase_scheduler #(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 12,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 5,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             next_ew_q, next_ew_d;
  logic             ped_pending_q, ped_pending_d;
  logic             conflict, own_car, green;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ALL_RED_B;
      timer_q       <= '0;
      next_ew_q     <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      next_ew_q     <= next_ew_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    next_ew_d     = next_ew_q;
    ped_pending_d = ped_pending_q | (ped_req & (state_q != PED_WALK));
    conflict      = 1'b0;
    own_car       = 1'b0;
    green         = 1'b0;
    if (tick) begin
      case (state_q)
        NS_GREEN, EW_GREEN: begin
          green    = 1'b1;
          conflict = ((state_q == NS_GREEN) ? ew_car : ns_car) | ped_pending_q;
          own_car  = (state_q == NS_GREEN) ? ns_car : ew_car;
          if (conflict && ((timer_q >= MIN_LAST && !own_car) || timer_q == MAX_LAST))
            state_d = (state_q == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
        end
        NS_YELLOW: if (timer_q == YELLOW_LAST) state_d = ALL_RED_A;
        EW_YELLOW: if (timer_q == YELLOW_LAST) state_d = ALL_RED_B;
        // Remember which green the clearance was heading to so the walk can resume it.
        ALL_RED_A: if (timer_q == ALLRED_LAST) begin
          next_ew_d = 1'b1;
          state_d   = ped_pending_q ? PED_WALK : EW_GREEN;
        end
        ALL_RED_B: if (timer_q == ALLRED_LAST) begin
          next_ew_d = 1'b0;
          state_d   = ped_pending_q ? PED_WALK : NS_GREEN;
        end
        PED_WALK: if (timer_q == WALK_LAST) state_d = next_ew_q ? EW_GREEN : NS_GREEN;
        default: state_d = ALL_RED_B;
      endcase
      if (state_d != state_q)
        timer_d = '0;
      else if (!(green && timer_q == MAX_LAST))
        timer_d = timer_q + CNT_W'(1);
    end
    if (state_d == PED_WALK && state_q != PED_WALK)
      ped_pending_d = 1'b0;
  end

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    ped_walk = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = 3'b001;
      NS_YELLOW: ns_light = 3'b010;
      EW_GREEN:  ew_light = 3'b001;
      EW_YELLOW: ew_light = 3'b010;
      PED_WALK:  ped_walk = 1'b1;
      default:   ;
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed stimulus for intersection_phase_scheduler; expected post-edge outputs are queued and checked by a monitor.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset, tick, ns_car, ew_car, ped_req;
  logic [2:0] ns_light, ew_light, phase;
  logic       ped_walk, ped_pending;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .ns_car(ns_car), .ew_car(ew_car),
    .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light),
    .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  // Light table per phase code: {ns_light, ew_light, ped_walk}
  function automatic logic [6:0] lights_for(input logic [2:0] ph);
    case (ph)
      3'd0:    lights_for = {3'b001, 3'b100, 1'b0};
      3'd1:    lights_for = {3'b010, 3'b100, 1'b0};
      3'd3:    lights_for = {3'b100, 3'b001, 1'b0};
      3'd4:    lights_for = {3'b100, 3'b010, 1'b0};
      3'd6:    lights_for = {3'b100, 3'b100, 1'b1};
      default: lights_for = {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0]  e;
    logic [10:0] act, req;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      req = {lights_for(e[3:1]), e[0], e[3:1]};
      act = {ns_light, ew_light, ped_walk, ped_pending, phase};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL step%0d t=%0t ns/ew/walk/pend/phase actual %b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                 checks, $time, act[10:8], act[7:5], act[4], act[3], act[2:0],
                 req[10:8], req[7:5], req[4], req[3], req[2:0]);
      end
    end
  end

  task automatic cyc(input logic [2:0] ph, input logic pend);
    exp_q.push_back({ph, pend});
    @(negedge clk);
  endtask

  task automatic cyc_n(input int n, input logic [2:0] ph, input logic pend);
    for (int i = 0; i < n; i++) cyc(ph, pend);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset ignores tick and ped_req
    reset = 1'b0; tick = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b1;
    cyc_n(3, 3'd5, 1'b0);
    reset = 1'b1; ped_req = 1'b0;
    cyc(3'd5, 1'b0);
    cyc(3'd0, 1'b0);
    // Rest in NS green with no demand
    cyc_n(50, 3'd0, 1'b0);
    // Saturated timer: gap-out on the first tick with EW demand
    ew_car = 1'b1;
    cyc_n(3, 3'd1, 1'b0);
    cyc_n(2, 3'd2, 1'b0);
    cyc_n(5, 3'd3, 1'b0);
    ns_car = 1'b1; ew_car = 1'b0;
    cyc_n(3, 3'd4, 1'b0);
    // Gap-out from NS green entry
    ns_car = 1'b0; ew_car = 1'b1;
    cyc_n(2, 3'd5, 1'b0);
    cyc_n(4, 3'd0, 1'b0);
    cyc_n(3, 3'd1, 1'b0);
    cyc_n(2, 3'd2, 1'b0);
    cyc(3'd3, 1'b0);
    // Max-out with both sensors held
    ns_car = 1'b1; ew_car = 1'b1;
    cyc_n(11, 3'd3, 1'b0);
    cyc_n(3, 3'd4, 1'b0);
    cyc_n(2, 3'd5, 1'b0);
    cyc_n(12, 3'd0, 1'b0);
    cyc_n(3, 3'd1, 1'b0);
    cyc_n(2, 3'd2, 1'b0);
    cyc_n(12, 3'd3, 1'b0);
    cyc_n(3, 3'd4, 1'b0);
    ns_car = 1'b0; ew_car = 1'b0;
    cyc_n(2, 3'd5, 1'b0);
    cyc(3'd0, 1'b0);
    // Pedestrian request at NS green timer 0
    ped_req = 1'b1;
    cyc(3'd0, 1'b1);
    ped_req = 1'b0;
    cyc_n(2, 3'd0, 1'b1);
    cyc_n(3, 3'd1, 1'b1);
    cyc_n(2, 3'd2, 1'b1);
    ped_req = 1'b1;
    cyc(3'd6, 1'b0);
    ped_req = 1'b0;
    cyc(3'd6, 1'b0);
    ped_req = 1'b1;
    cyc(3'd6, 1'b0);
    ped_req = 1'b0;
    cyc_n(2, 3'd6, 1'b0);
    cyc_n(5, 3'd3, 1'b0);
    // Freeze in EW yellow, then reset mid-phase
    ns_car = 1'b1;
    cyc_n(2, 3'd4, 1'b0);
    tick = 1'b0; ped_req = 1'b1;
    cyc(3'd4, 1'b1);
    ped_req = 1'b0;
    cyc_n(9, 3'd4, 1'b1);
    tick = 1'b1;
    cyc(3'd4, 1'b1);
    tick = 1'b0;
    cyc_n(10, 3'd4, 1'b1);
    reset = 1'b0; tick = 1'b1;
    cyc(3'd5, 1'b0);
    // Request latched after release diverts clearance into a walk
    reset = 1'b1; ped_req = 1'b1;
    cyc(3'd5, 1'b1);
    ped_req = 1'b0;
    cyc(3'd6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b0;
      cyc(3'd6, 1'b0);
      tick = 1'b1;
      cyc(3'd6, 1'b0);
    end
    tick = 1'b0;
    cyc(3'd6, 1'b0);
    tick = 1'b1;
    cyc(3'd0, 1'b0);
    cyc_n(3, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
